control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Moore control sequencer for the single-bus Mini SRC datapath.
- Drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the register select/encode logic, plus the PC, MAR, MDR, IR, Y, Z and memory strobes.
- Steps each instruction through fetch and execute T-states, with wait states on memory handshakes.

Parameters:
- none

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
ir_op  in  5  IR[31:27] opcode
stop  in  1  halt request, sampled at instruction boundary
mem_ready  in  1  memory completes the current Read/Write this cycle
run  out  1  1 while executing; 0 in RESET or HALT
PCout, PCin, IncPC  out  1 each  PC strobes
MARin, MDRin, MDRout  out  1 each  MAR/MDR strobes
Read, Write  out  1 each  memory strobes
IRin, Yin, Zin, Zlowout, Cout  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls
alu_op  out  5  ALU operation code

Behaviour:
- Reset and output decode
  - clear low (async): state=RESET, every output 0, alu_op=0.
  - First rising edge after clear deasserts: RESET->T0.
  - All outputs are decoded from the state register only, plus ir_op for alu_op. There are no combinational paths from stop or mem_ready.
  - Any output not listed for a state is 0.
- Opcodes
  - ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110.
  - addi=01100, andi=01101, ori=01110.
  - jr=10100, nop=11000, halt=11001.
  - Any other opcode executes as nop.
- Fetch
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Held until mem_ready=1.
  - T2: MDRout, IRin.
  - Execution branches on ir_op at T3, which is one cycle after IRin.
- Execute: R-type (add/sub/and/or)
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=ir_op.
  - T5: Zlowout, Gra, Rin.
- Execute: I-type (addi/andi/ori)
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op=00011/00101/00110 respectively.
  - T5: Zlowout, Gra, Rin.
- Execute: ldi
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin.
- Execute: ld
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Held until mem_ready=1.
  - T7: MDRout, Gra, Rin.
- Execute: st
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin, with Read=0 so the MDR loads from the bus.
  - T7: Write. Held until mem_ready=1.
- Execute: jr, nop, halt
  - jr — T3: Gra, Rout, PCin.
  - nop — T3: no strobes.
  - halt — T3->HALT.
- Instruction end and HALT
  - The last execute state goes to T0 if stop=0, or HALT if stop=1.
  - HALT: run=0, all strobes 0. Exited only by clear.
  - alu_op=0 in every state except T4 of ALU-using classes.
- Wait states
  - While mem_ready=0 in T1, ld-T6 or st-T7, the state and all outputs are held. There is no timeout.
  - mem_ready=1 on the first cycle of such a state advances on the next edge, so the state lasts one cycle.
  - mem_ready is ignored in all other states.
- Simultaneous events
  - clear overrides everything, including mid-wait and mid-instruction; no partial instruction is resumed.
  - stop asserted mid-instruction has no effect until the boundary. It must still be high at the boundary.
- Exclusivity
  - At most one of {Gra, Grb, Grc} is 1 in any state.
  - Rin and Rout are never both 1.
  - Read and Write are never both 1.

Test Plan:
- Reset: drive clear=0 mid-T4 of add -> all outputs 0 immediately. Release clear -> RESET, then T0 on the next edge, with PCout=MARin=IncPC=Zin=1.
- R-type with mem_ready tied 1: ir_op=00100 (sub) -> 6-cycle instruction. T4 shows Grc=Rout=Zin=1 and alu_op=00100. T5 shows Gra=Rin=Zlowout=1.
- Fetch wait: mem_ready=0 for 3 cycles in T1 -> T1 persists 4 cycles with outputs stable. IRin pulses exactly once, in the cycle after mem_ready=1.
- ld vs st: ir_op=00000 -> T6 Read=MDRin=1, T7 MDRout=Gra=Rin=1, total 8 cycles. ir_op=00010 with mem_ready=0 for 2 cycles in T7 -> Write held 3 cycles, never with Read.
- Immediates and ldi: ir_op=01101 (andi) -> T4 Cout=1, alu_op=00101. ir_op=00001 (ldi) -> T3 BAout=Grb=Yin=1, T4 alu_op=00011.
- Halt and stop: ir_op=11001 -> run=0 after T3 and stays 0 for 20 cycles. Separately, stop pulsed high during T4 only of add, low at T5 -> next fetch proceeds. stop high at T5 -> HALT.
- Unknown opcode: ir_op=11111 -> nop timing (T0–T3, back to T0), with no register strobes.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer for the single-bus Mini SRC datapath.
// Fetch/execute T-states with memory wait states on T1, ld-T6, st-T7.
module control_sequencer (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] ir_op,
  input  logic       stop,
  input  logic       mem_ready,
  output logic       run,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Read,
  output logic       Write,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Cout,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic [4:0] alu_op
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11001;

  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_R4, S_R5, S_I4, S_I5,
    S_L4, S_L5, S_L6, S_L7,
    S_S4, S_S5, S_S6, S_S7,
    S_HALT
  } state_t;

  state_t state;
  state_t done_state;

  logic is_r, is_i, is_ldi, is_ld, is_st, is_jr, is_halt;
  logic [4:0] imm_alu;

  assign is_r = (ir_op == OP_ADD) || (ir_op == OP_SUB)
             || (ir_op == OP_AND) || (ir_op == OP_OR);
  assign is_i = (ir_op == OP_ADDI) || (ir_op == OP_ANDI)
             || (ir_op == OP_ORI);
  assign is_ldi  = (ir_op == OP_LDI);
  assign is_ld   = (ir_op == OP_LD);
  assign is_st   = (ir_op == OP_ST);
  assign is_jr   = (ir_op == OP_JR);
  assign is_halt = (ir_op == OP_HALT);

  // Immediate forms reuse the register-form ALU codes; ld/st/ldi add.
  assign imm_alu = (ir_op == OP_ANDI) ? OP_AND :
                   (ir_op == OP_ORI)  ? OP_OR  : OP_ADD;

  assign done_state = stop ? S_HALT : S_T0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (mem_ready) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          unique case (1'b1)
            is_r:            state <= S_R4;
            is_i || is_ldi:  state <= S_I4;
            is_ld:           state <= S_L4;
            is_st:           state <= S_S4;
            is_halt:         state <= S_HALT;
            default:         state <= done_state;
          endcase
        end
        S_R4:    state <= S_R5;
        S_R5:    state <= done_state;
        S_I4:    state <= S_I5;
        S_I5:    state <= done_state;
        S_L4:    state <= S_L5;
        S_L5:    state <= S_L6;
        S_L6:    if (mem_ready) state <= S_L7;
        S_L7:    state <= done_state;
        S_S4:    state <= S_S5;
        S_S5:    state <= S_S6;
        S_S6:    state <= S_S7;
        S_S7:    if (mem_ready) state <= done_state;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    run     = 1'b1;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = 5'd0;
    unique case (state)
      S_RESET, S_HALT: run = 1'b0;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_r || is_i: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          is_ldi || is_ld || is_st: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          is_jr: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_R4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = ir_op;
      end
      S_I4, S_L4, S_S4: begin
        Cout   = 1'b1;
        Zin    = 1'b1;
        alu_op = imm_alu;
      end
      S_R5, S_I5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      S_L5, S_S5: begin
        Zlowout = 1'b1;
        MARin   = 1'b1;
      end
      S_L6: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_L7: begin
        MDRout = 1'b1;
        Gra    = 1'b1;
        Rin    = 1'b1;
      end
      // Read stays low so the MDR takes the register value off the bus.
      S_S6: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        MDRin = 1'b1;
      end
      S_S7: Write = 1'b1;
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction phase model,
// randomized opcodes, wait lengths and mid-instruction stop.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [4:0] ir_op = 5'd0;
  logic       stop = 1'b0;
  logic       mem_ready = 1'b1;
  logic       run, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic       Read, Write, IRin, Yin, Zin, Zlowout, Cout;
  logic       Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir_op(ir_op), .stop(stop),
    .mem_ready(mem_ready), .run(run), .PCout(PCout), .PCin(PCin),
    .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op)
  );

  always #5 clock = ~clock;

  localparam logic [24:0] M_RUN  = 25'd1 << 24;
  localparam logic [24:0] M_PCO  = 25'd1 << 23;
  localparam logic [24:0] M_PCI  = 25'd1 << 22;
  localparam logic [24:0] M_INC  = 25'd1 << 21;
  localparam logic [24:0] M_MAR  = 25'd1 << 20;
  localparam logic [24:0] M_MDI  = 25'd1 << 19;
  localparam logic [24:0] M_MDO  = 25'd1 << 18;
  localparam logic [24:0] M_RD   = 25'd1 << 17;
  localparam logic [24:0] M_WR   = 25'd1 << 16;
  localparam logic [24:0] M_IR   = 25'd1 << 15;
  localparam logic [24:0] M_Y    = 25'd1 << 14;
  localparam logic [24:0] M_Z    = 25'd1 << 13;
  localparam logic [24:0] M_ZLO  = 25'd1 << 12;
  localparam logic [24:0] M_C    = 25'd1 << 11;
  localparam logic [24:0] M_GRA  = 25'd1 << 10;
  localparam logic [24:0] M_GRB  = 25'd1 << 9;
  localparam logic [24:0] M_GRC  = 25'd1 << 8;
  localparam logic [24:0] M_RIN  = 25'd1 << 7;
  localparam logic [24:0] M_ROUT = 25'd1 << 6;
  localparam logic [24:0] M_BA   = 25'd1 << 5;

  logic [24:0] dut_vec;
  assign dut_vec = {run, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                    Read, Write, IRin, Yin, Zin, Zlowout, Cout,
                    Gra, Grb, Grc, Rin, Rout, BAout, alu_op};

  logic [24:0] exp_q[$];
  logic [24:0] ph_vec[$];
  bit          ph_wait[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          active = 1'b0;

  task automatic check(input logic [24:0] act, input logic [24:0] exp,
                       input string name);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (active) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_empty: got output with no expectation at %0t",
                 $time);
      end else begin
        check(dut_vec, exp_q.pop_front(), "cycle_outputs");
      end
      n_cmp++;
      if ($countones({Gra, Grb, Grc}) > 1 || (Rin && Rout) ||
          (Read && Write)) begin
        n_bad++;
        $display("FAIL exclusive: got %b required at most one of each group",
                 {Gra, Grb, Grc, Rin, Rout, Read, Write});
      end
    end
  end

  task automatic ph(input logic [24:0] v, input bit w);
    ph_vec.push_back(v | M_RUN);
    ph_wait.push_back(w);
  endtask

  // Phase list of one instruction as the control table describes it.
  task automatic build(input logic [4:0] op, output bit halts);
    logic [24:0] a;
    halts = 1'b0;
    ph_vec.delete();
    ph_wait.delete();
    ph(M_PCO | M_MAR | M_INC | M_Z, 1'b0);
    ph(M_ZLO | M_PCI | M_RD | M_MDI, 1'b1);
    ph(M_MDO | M_IR, 1'b0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        ph(M_GRB | M_ROUT | M_Y, 1'b0);
        ph(M_GRC | M_ROUT | M_Z | 25'(op), 1'b0);
        ph(M_ZLO | M_GRA | M_RIN, 1'b0);
      end
      5'd12, 5'd13, 5'd14: begin
        a = (op == 5'd12) ? 25'd3 : (op == 5'd13) ? 25'd5 : 25'd6;
        ph(M_GRB | M_ROUT | M_Y, 1'b0);
        ph(M_C | M_Z | a, 1'b0);
        ph(M_ZLO | M_GRA | M_RIN, 1'b0);
      end
      5'd1: begin
        ph(M_GRB | M_BA | M_Y, 1'b0);
        ph(M_C | M_Z | 25'd3, 1'b0);
        ph(M_ZLO | M_GRA | M_RIN, 1'b0);
      end
      5'd0: begin
        ph(M_GRB | M_BA | M_Y, 1'b0);
        ph(M_C | M_Z | 25'd3, 1'b0);
        ph(M_ZLO | M_MAR, 1'b0);
        ph(M_RD | M_MDI, 1'b1);
        ph(M_MDO | M_GRA | M_RIN, 1'b0);
      end
      5'd2: begin
        ph(M_GRB | M_BA | M_Y, 1'b0);
        ph(M_C | M_Z | 25'd3, 1'b0);
        ph(M_ZLO | M_MAR, 1'b0);
        ph(M_GRA | M_ROUT | M_MDI, 1'b0);
        ph(M_WR, 1'b1);
      end
      5'd20: ph(M_GRA | M_ROUT | M_PCI, 1'b0);
      5'd25: begin
        ph(25'd0, 1'b0);
        halts = 1'b1;
      end
      default: ph(25'd0, 1'b0);
    endcase
  endtask

  task automatic drive(input logic [24:0] v);
    exp_q.push_back(v);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    active = 1'b0;
    clear = 1'b0;
    #1;
    check(dut_vec, 25'd0, "reset_async");
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    stop = 1'b0;
    active = 1'b1;
    drive(25'd0);
  endtask

  task automatic run_instr(input logic [4:0] op, input int w1,
                           input int w2, input bit stop_end,
                           input int abort_at, input int halt_cycles);
    bit halts;
    int cyc;
    cyc = 0;
    build(op, halts);
    ir_op = op;
    for (int p = 0; p < ph_vec.size(); p++) begin
      int w;
      w = 0;
      if (ph_wait[p]) w = (p == 1) ? w1 : w2;
      if (w < 0) w = $urandom_range(0, 3);
      for (int k = 0; k <= w; k++) begin
        if (cyc == abort_at) begin
          check(dut_vec, ph_vec[p], "pre_abort");
          #2;
          do_reset();
          return;
        end
        mem_ready = ph_wait[p] ? (k == w) : 1'($urandom_range(0, 1));
        if (p == ph_vec.size() - 1 && k == w) stop = stop_end;
        else stop = 1'($urandom_range(0, 1));
        drive(ph_vec[p]);
        cyc++;
      end
    end
    if (halts || stop_end) begin
      repeat (halt_cycles) begin
        stop = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        drive(25'd0);
      end
      do_reset();
    end
  endtask

  logic [4:0] ops[12];

  initial begin
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
            5'd12, 5'd13, 5'd14, 5'd20, 5'd25};
    #2;
    do_reset();
    run_instr(5'd3, 0, 0, 1'b0, 4, 0);
    run_instr(5'd4, 0, 0, 1'b0, -1, 0);
    run_instr(5'd24, 3, 0, 1'b0, -1, 0);
    run_instr(5'd0, 0, 0, 1'b0, -1, 0);
    run_instr(5'd2, 0, 2, 1'b0, -1, 0);
    run_instr(5'd13, 0, 0, 1'b0, -1, 0);
    run_instr(5'd1, 0, 0, 1'b0, -1, 0);
    run_instr(5'd31, 0, 0, 1'b0, -1, 0);
    run_instr(5'd20, 1, 0, 1'b0, -1, 0);
    run_instr(5'd3, 0, 0, 1'b1, -1, 5);
    run_instr(5'd25, 0, 0, 1'b0, -1, 20);
    repeat (80) begin
      logic [4:0] op;
      int sel;
      sel = $urandom_range(0, 15);
      op = (sel < 12) ? ops[sel] : 5'($urandom_range(0, 31));
      run_instr(op, -1, -1, ($urandom_range(0, 9) == 0), -1,
                $urandom_range(1, 4));
    end
    active = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
